key_bcd_counter: RTL and testbench

KEY_BCD_COUNTER -- requirements
Module: key_bcd_counter

---
 rtl/key_bcd_counter.sv | 152 +++++++++++++++
 tb/tb_key_bcd_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_bcd_counter.sv
// Two-digit BCD counter driven by four debounced push-buttons (inc, dec, load, clear).
// Optional hold-to-repeat on inc/dec is built when KEY_AUTOREPEAT_EN is defined.
module key_bcd_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       upd,
    output logic [3:0] key_state
);

    localparam logic [18:0] DB_LAST = 19'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  key_meta;
    logic [3:0]  key_sync;
    logic [3:0]  key_prev;
    logic [18:0] db_cnt [4];
    logic [3:0]  press;
    logic        inc_ev;
    logic        dec_ev;
    logic [3:0]  hi_d;
    logic [3:0]  lo_d;
    logic        upd_d;

    // REPEAT_CYCLES is only consumed by the auto-repeat build; SW[5:4] has no function.
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_CYCLES, SW[5:4]};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_meta <= 4'hF;
            key_sync <= 4'hF;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_state <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_sync[i] == key_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    key_state[i] <= key_sync[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 19'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_prev <= 4'hF;
        end else begin
            key_prev <= key_state;
        end
    end

    // Press only: debounced level falling from 1 to 0.
    assign press = key_prev & ~key_state;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_hold;
    logic             rpt_press;
    logic             rpt_fire;

    assign rpt_hold  = ~key_state[0] | ~key_state[1];
    assign rpt_press = press[0] | press[1];
    assign rpt_fire  = rpt_hold & ~rpt_press & (rpt_cnt == RPT_LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rpt_cnt <= '0;
        end else if (rpt_press || !rpt_hold || rpt_cnt == RPT_LAST) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign inc_ev = press[0] | (rpt_fire & ~key_state[0]);
    assign dec_ev = press[1] | (rpt_fire & ~key_state[1]);
`else
    assign inc_ev = press[0];
    assign dec_ev = press[1];
`endif

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        hi_d  = digit_hi;
        lo_d  = digit_lo;
        upd_d = 1'b0;
        if (press[3]) begin
            hi_d  = 4'd0;
            lo_d  = 4'd0;
            upd_d = 1'b1;
        end else if (press[2]) begin
            hi_d  = clamp9(SW[9:6]);
            lo_d  = clamp9(SW[3:0]);
            upd_d = 1'b1;
        end else if (inc_ev && !dec_ev) begin
            upd_d = 1'b1;
            if (digit_lo == 4'd9) begin
                lo_d = 4'd0;
                hi_d = (digit_hi == 4'd9) ? 4'd0 : digit_hi + 4'd1;
            end else begin
                lo_d = digit_lo + 4'd1;
            end
        end else if (dec_ev && !inc_ev) begin
            upd_d = 1'b1;
            if (digit_lo == 4'd0) begin
                lo_d = 4'd9;
                hi_d = (digit_hi == 4'd0) ? 4'd9 : digit_hi - 4'd1;
            end else begin
                lo_d = digit_lo - 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            digit_hi <= 4'd0;
            digit_lo <= 4'd0;
            upd      <= 1'b0;
        end else begin
            digit_hi <= hi_d;
            digit_lo <= lo_d;
            upd      <= upd_d;
        end
    end

endmodule

// File: tb/tb_key_bcd_counter.sv
// Self-checking bench for key_bcd_counter: directed scenarios plus random presses
// checked against an integer 0..99 count model.
module tb_key_bcd_counter;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic [3:0] KEY      = 4'hF;
    logic [9:0] SW       = '0;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic       upd;
    logic [3:0] key_state;

    int tests = 0;
    int fails = 0;
    int upd_seen = 0;
    int model = 0;
    int base;

    key_bcd_counter #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (20)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY      (KEY),
        .SW       (SW),
        .digit_hi (digit_hi),
        .digit_lo (digit_lo),
        .upd      (upd),
        .key_state(key_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (upd === 1'b1) upd_seen <= upd_seen + 1;
    end

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    function automatic logic [7:0] model_digits(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Hold the masked keys low for 'hold' clocks, then release and let things settle.
    task automatic drive(input logic [3:0] mask, input int hold, input int settle);
        @(negedge CLOCK_50);
        KEY = KEY & ~mask;
        repeat (hold) @(negedge CLOCK_50);
        KEY = KEY | mask;
        repeat (settle) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK_50);
        tests++;
        if ({digit_hi, digit_lo} !== 8'h00) begin
            fails++;
            $display("FAIL reset_digits: got %h expected 00", {digit_hi, digit_lo});
        end
        tests++;
        if (upd !== 1'b0) begin
            fails++;
            $display("FAIL reset_upd: got %b expected 0", upd);
        end
        tests++;
        if (key_state !== 4'hF) begin
            fails++;
            $display("FAIL reset_key_state: got %h expected f", key_state);
        end
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_glitch();
        base = upd_seen;
        drive(4'b0001, 3, 12);
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model) || upd_seen != base) begin
            fails++;
            $display("FAIL glitch: got %h upd %0d expected %h upd 0",
                     {digit_hi, digit_lo}, upd_seen - base, model_digits(model));
        end
        base = upd_seen;
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        tests++;
        if (key_state !== 4'hE) begin
            fails++;
            $display("FAIL held_key_state: got %h expected e", key_state);
        end
        KEY[0] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        model = 1;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model) || upd_seen != base + 1) begin
            fails++;
            $display("FAIL clean_press: got %h upd %0d expected %h upd 1",
                     {digit_hi, digit_lo}, upd_seen - base, model_digits(model));
        end
    endtask

    task automatic test_load_wrap();
        SW = 10'b1001_00_1001;
        drive(4'b0100, 8, 12);
        model = 99;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model)) begin
            fails++;
            $display("FAIL load_99: got %h expected %h", {digit_hi, digit_lo}, model_digits(model));
        end
        drive(4'b0001, 8, 12);
        model = (model + 1) % 100;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model)) begin
            fails++;
            $display("FAIL inc_wrap: got %h expected %h", {digit_hi, digit_lo}, model_digits(model));
        end
        drive(4'b0010, 8, 12);
        model = (model + 99) % 100;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model)) begin
            fails++;
            $display("FAIL dec_wrap: got %h expected %h", {digit_hi, digit_lo}, model_digits(model));
        end
    endtask

    task automatic test_clamp();
        drive(4'b1000, 8, 12);
        model = 0;
        SW = 10'b1111_00_1010;
        drive(4'b0100, 8, 12);
        model = clamp9(15) * 10 + clamp9(10);
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model)) begin
            fails++;
            $display("FAIL load_clamp: got %h expected %h", {digit_hi, digit_lo}, model_digits(model));
        end
    endtask

    task automatic test_simultaneous();
        SW = 10'b0100_00_0111;
        drive(4'b0100, 8, 12);
        model = 47;
        base = upd_seen;
        drive(4'b1100, 8, 12);
        model = 0;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model) || upd_seen != base + 1) begin
            fails++;
            $display("FAIL clear_and_load: got %h upd %0d expected %h upd 1",
                     {digit_hi, digit_lo}, upd_seen - base, model_digits(model));
        end
        drive(4'b0100, 8, 12);
        model = 47;
        base = upd_seen;
        drive(4'b0011, 8, 12);
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model) || upd_seen != base) begin
            fails++;
            $display("FAIL inc_and_dec: got %h upd %0d expected %h upd 0",
                     {digit_hi, digit_lo}, upd_seen - base, model_digits(model));
        end
    endtask

    task automatic test_autorepeat();
        int exp_events;
        drive(4'b1000, 8, 12);
        model = 0;
        base = upd_seen;
        drive(4'b0001, 70, 20);
`ifdef KEY_AUTOREPEAT_EN
        exp_events = 4;
`else
        exp_events = 1;
`endif
        model = (model + exp_events) % 100;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model) || upd_seen != base + exp_events) begin
            fails++;
            $display("FAIL long_hold: got %h upd %0d expected %h upd %0d",
                     {digit_hi, digit_lo}, upd_seen - base, model_digits(model), exp_events);
        end
    endtask

    task automatic test_reset_mid();
        SW = 10'b0101_00_0111;
        drive(4'b0100, 8, 12);
        model = 57;
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        #2 RESET = 1'b1;
        #1;
        tests++;
        if ({digit_hi, digit_lo} !== 8'h00 || upd !== 1'b0 || key_state !== 4'hF) begin
            fails++;
            $display("FAIL async_reset: got digits %h upd %b keys %h expected 00 0 f",
                     {digit_hi, digit_lo}, upd, key_state);
        end
        @(negedge CLOCK_50);
        RESET = 1'b0;
        model = 0;
        base = upd_seen;
        repeat (10) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        model = 1;
        tests++;
        if ({digit_hi, digit_lo} !== model_digits(model) || upd_seen != base + 1) begin
            fails++;
            $display("FAIL press_after_reset: got %h upd %0d expected %h upd 1",
                     {digit_hi, digit_lo}, upd_seen - base, model_digits(model));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int  k;
            int  hold;
            bit  glitch;
            k      = $urandom_range(0, 3);
            SW     = 10'($urandom);
            glitch = ($urandom_range(0, 4) == 0);
            hold   = glitch ? $urandom_range(1, 3) : $urandom_range(6, 12);
            base   = upd_seen;
            drive(4'(1 << k), hold, 12);
            if (!glitch) begin
                case (k)
                    0: model = (model + 1) % 100;
                    1: model = (model + 99) % 100;
                    2: model = clamp9(int'(SW[9:6])) * 10 + clamp9(int'(SW[3:0]));
                    default: model = 0;
                endcase
            end
            tests++;
            if ({digit_hi, digit_lo} !== model_digits(model)) begin
                fails++;
                $display("FAIL random_count[%0d] key %0d hold %0d: got %h expected %h",
                         n, k, hold, {digit_hi, digit_lo}, model_digits(model));
            end
            tests++;
            if (upd_seen != base + (glitch ? 0 : 1)) begin
                fails++;
                $display("FAIL random_upd[%0d] key %0d hold %0d: got %0d expected %0d",
                         n, k, hold, upd_seen - base, glitch ? 0 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_load_wrap();
        test_clamp();
        test_simultaneous();
        test_autorepeat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
